// File: rtl/sub_narrow_if.sv
// sub_narrow_if: operand and result handshake bundle for sub_narrow
interface sub_narrow_if #(
    parameter int WIDTH = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH:0]   a;
    logic signed [WIDTH:0]   b;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] y;
    logic                    sat;
    modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, y, sat);
    modport slave  (input in_valid, a, b, out_ready, output in_ready, out_valid, y, sat);
endinterface

// File: rtl/sub_narrow.sv
// sub_narrow: pipelined (a-b)/2^SHIFT with round-half-up and saturation; SUB_NARROW_OVFCNT_EN adds the overflow counter
module sub_narrow #(
    parameter int WIDTH = 8,
    parameter int SHIFT = 1
) (
    input  logic          clk,
    input  logic          resetn,
    sub_narrow_if.slave   bus,
    input  logic          ovf_clr,
    output logic [7:0]    ovf_cnt
);
    localparam int IW = WIDTH + 3;
    localparam logic signed [IW-1:0] RND  = (IW'(1) << SHIFT) >> 1;
    localparam logic signed [IW-1:0] MAXV = (IW'(1) << (WIDTH - 1)) - IW'(1);
    localparam logic signed [IW-1:0] MINV = -MAXV - IW'(1);
    logic                 v1, v2, sat_q, ld1, ld2, hi, lo;
    logic signed [IW-1:0] d, q;
    logic [WIDTH-1:0]     y_q;
    assign ld2          = v1 & (~v2 | bus.out_ready);
    assign ld1          = ~v1 | ld2;
    assign bus.in_ready = resetn & ld1;
    assign q            = (d + RND) >>> SHIFT;
    assign hi           = q > MAXV;
    assign lo           = q < MINV;
    assign bus.out_valid = v2;
    assign bus.y        = y_q;
    assign bus.sat      = sat_q;
    // S1 holds the wide difference, S2 the rounded/clipped result
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v1    <= 1'b0;
            d     <= '0;
            v2    <= 1'b0;
            y_q   <= '0;
            sat_q <= 1'b0;
        end else begin
            if (ld1) begin
                v1 <= bus.in_valid;
                if (bus.in_valid) d <= IW'(bus.a) - IW'(bus.b);
            end
            if (~v2 | bus.out_ready) v2 <= v1;
            if (ld2) begin
                y_q   <= hi ? MAXV[WIDTH-1:0] : lo ? MINV[WIDTH-1:0] : q[WIDTH-1:0];
                sat_q <= hi | lo;
            end
        end
    end
`ifdef SUB_NARROW_OVFCNT_EN
    logic [7:0] cnt;
    assign ovf_cnt = cnt;
    // counts delivered saturated results, sticks at 255, clear wins
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cnt <= '0;
        else if (ovf_clr) cnt <= '0;
        else if (v2 & bus.out_ready & sat_q & (cnt != 8'hff)) cnt <= cnt + 8'd1;
    end
`else
    assign ovf_cnt = {7'd0, ovf_clr & 1'b0};
`endif
endmodule

// File: tb/tb_sub_narrow.sv
// tb_sub_narrow: directed and random checks of sub_narrow against a behavioural model
module tb_sub_narrow;
    localparam int W = 8;
    localparam int S = 1;
    typedef struct {int y; int s;} res_t;

    logic       clk, resetn, ovf_clr;
    logic [7:0] ovf_cnt;
    int         checks = 0, failures = 0;
    res_t       q[$];
    int         got[$];
    int         exp_cnt = 0;
    logic       hold_prev = 0;
    int         prev_y = 0, prev_s = 0;
    logic       ov_s, ir_s;

    sub_narrow_if #(.WIDTH(W)) bus ();
    sub_narrow #(.WIDTH(W), .SHIFT(S)) dut (.clk(clk), .resetn(resetn), .bus(bus), .ovf_clr(ovf_clr), .ovf_cnt(ovf_cnt));

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input int a, input int b);
        res_t r;
        int v;
        v = ((a - b) + (S > 0 ? (1 << (S - 1)) : 0)) >>> S;
        r.s = (v > 127 || v < -128) ? 1 : 0;
        r.y = v > 127 ? 127 : (v < -128 ? -128 : v);
        return r;
    endfunction

    task automatic cyc(input logic iv, input int ia, input int ib, input logic ior, input logic iclr);
        res_t e;
        int yv;
        bus.in_valid  = iv;
        bus.a         = ia[W:0];
        bus.b         = ib[W:0];
        bus.out_ready = ior;
        ovf_clr       = iclr;
        @(negedge clk);
        ov_s = bus.out_valid;
        ir_s = bus.in_ready;
        yv   = int'($signed(bus.y));
        chk("in_ready", int'(bus.in_ready), int'(q.size() < 2 || ior));
        chk("ovf_cnt", int'(ovf_cnt), exp_cnt);
        if (q.size() == 0) chk("stale_valid", int'(bus.out_valid), 0);
        if (hold_prev) begin
            chk("hold_valid", int'(bus.out_valid), 1);
            chk("hold_y", yv, prev_y);
            chk("hold_sat", int'(bus.sat), prev_s);
        end
        if (bus.out_valid && ior && q.size() > 0) begin
            e = q.pop_front();
            chk("y", yv, e.y);
            chk("sat", int'(bus.sat), e.s);
            got.push_back(yv);
`ifdef SUB_NARROW_OVFCNT_EN
            if (e.s == 1 && exp_cnt < 255) exp_cnt++;
`endif
        end
        if (iclr) exp_cnt = 0;
        if (iv && bus.in_ready) q.push_back(model(ia, ib));
        hold_prev = bus.out_valid && !ior;
        prev_y    = yv;
        prev_s    = int'(bus.sat);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int val, acc, a, b;
        int exp_y[$];
        resetn = 0; ovf_clr = 0;
        bus.in_valid = 0; bus.a = '0; bus.b = '0; bus.out_ready = 0;
        #3;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_y", int'(bus.y), 0);
        chk("rst_sat", int'(bus.sat), 0);
        chk("rst_cnt", int'(ovf_cnt), 0);
        chk("rst_in_ready", int'(bus.in_ready), 0);
        repeat (2) @(posedge clk);
        #1 resetn = 1;

        // latency: valid exactly two cycles after the transfer, for one cycle
        cyc(1, 100, -50, 1, 0); chk("lat0", int'(ov_s), 0);
        cyc(0, 0, 0, 1, 0);     chk("lat1", int'(ov_s), 0);
        cyc(0, 0, 0, 1, 0);     chk("lat2", int'(ov_s), 1);
        cyc(0, 0, 0, 1, 0);     chk("lat3", int'(ov_s), 0);
        chk("y75", got[got.size()-1], 75);

        // saturation in both directions
        cyc(1, 255, -256, 1, 0);
        cyc(1, -256, 255, 1, 0);
        repeat (3) cyc(0, 0, 0, 1, 0);
        chk("sat_hi", got[got.size()-2], 127);
        chk("sat_lo", got[got.size()-1], -128);
`ifdef SUB_NARROW_OVFCNT_EN
        chk("cnt2", int'(ovf_cnt), 2);
`else
        chk("cnt2", int'(ovf_cnt), 0);
`endif

        // rounding half toward +inf
        got.delete();
        cyc(1, 3, 0, 1, 0); cyc(1, -3, 0, 1, 0); cyc(1, 1, 0, 1, 0); cyc(1, -1, 0, 1, 0);
        repeat (3) cyc(0, 0, 0, 1, 0);
        exp_y = '{2, -1, 1, 0};
        chk("rnd_n", got.size(), 4);
        foreach (exp_y[i]) if (i < got.size()) chk("rnd", got[i], exp_y[i]);

        // backpressure: two held, then drain in order
        got.delete();
        val = 1; acc = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(1, val, 0, 0, 0);
            if (ir_s) begin val++; acc++; end
        end
        chk("bp_accepted", acc, 2);
        chk("bp_in_ready", int'(bus.in_ready), 0);
        for (int i = 0; i < 20 && val <= 4; i++) begin
            cyc(1, val, 0, 1, 0);
            if (ir_s) val++;
        end
        repeat (3) cyc(0, 0, 0, 1, 0);
        exp_y = '{1, 1, 2, 2};
        chk("bp_n", got.size(), 4);
        foreach (exp_y[i]) if (i < got.size()) chk("bp_order", got[i], exp_y[i]);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            a = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 255 : -256) : int'($urandom_range(0, 511)) - 256;
            b = int'($urandom_range(0, 511)) - 256;
            cyc(1'($urandom_range(0, 1)), a, b, 1'($urandom_range(0, 3) != 0), 0);
        end
        repeat (4) cyc(0, 0, 0, 1, 0);

        // counter saturates at 255, clear wins over increment
        for (int i = 0; i < 300; i++) cyc(1, 255, -256, 1, 0);
        repeat (3) cyc(0, 0, 0, 1, 0);
`ifdef SUB_NARROW_OVFCNT_EN
        chk("cnt255", int'(ovf_cnt), 255);
`else
        chk("cnt255", int'(ovf_cnt), 0);
`endif
        cyc(1, -256, 255, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 1); chk("clr_with_sat", int'(ov_s), 1);
        cyc(0, 0, 0, 1, 0);
        chk("cnt_clr", int'(ovf_cnt), 0);

        // asynchronous reset with two results pending
        cyc(1, 10, 0, 0, 0);
        cyc(1, 20, 0, 0, 0);
        #2 resetn = 0;
        #1;
        chk("ar_out_valid", int'(bus.out_valid), 0);
        chk("ar_y", int'(bus.y), 0);
        chk("ar_in_ready", int'(bus.in_ready), 0);
        chk("ar_cnt", int'(ovf_cnt), 0);
        q.delete(); exp_cnt = 0; hold_prev = 0;
        @(posedge clk);
        #1 resetn = 1;
        cyc(0, 0, 0, 1, 0); chk("ar_ready_after", int'(ir_s), 1);
        repeat (4) cyc(0, 0, 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
